// File: rtl/wb_sram_responder.sv
// Wishbone classic target in front of a single-port OpenRAM-style SRAM macro.
// One macro access per request, registered outputs, one-cycle ack/err.
module wb_sram_responder #(
  parameter int ADDR_WIDTH   = 10,
  parameter int DEPTH        = 256,
  parameter int MEM_AW       = 8,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  wb_cyc_i,
  input  logic                  wb_stb_i,
  input  logic                  wb_we_i,
  input  logic [3:0]            wb_sel_i,
  input  logic [ADDR_WIDTH-1:0] wb_addr_i,
  input  logic [31:0]           wb_dat_i,
  output logic                  wb_ack_o,
  output logic                  wb_err_o,
  output logic [31:0]           wb_dat_o,
  output logic                  mem_csb_o,
  output logic                  mem_web_o,
  output logic [3:0]            mem_wmask_o,
  output logic [MEM_AW-1:0]     mem_addr_o,
  output logic [31:0]           mem_din_o,
  input  logic [31:0]           mem_dout_i
);
  localparam int IDX_W = ADDR_WIDTH - 2;

  typedef enum logic [2:0] {IDLE, WRITE, READ, WAIT, ACK, ERR} state_t;

  state_t              state, state_nx;
  logic [1:0]          lat_cnt, lat_cnt_nx;
  logic                ack_nx, err_nx, csb_nx, web_nx;
  logic [3:0]          wmask_nx;
  logic [MEM_AW-1:0]   addr_nx;
  logic [31:0]         din_nx, dat_nx;
  logic [IDX_W-1:0]    idx;
  logic                out_of_range;
  logic                unused_addr_lsb;

  assign idx             = wb_addr_i[ADDR_WIDTH-1:2];
  assign out_of_range    = {{(32-IDX_W){1'b0}}, idx} >= 32'(DEPTH);
  assign unused_addr_lsb = &{1'b0, wb_addr_i[1:0]};

  // Every output is computed here one cycle early and registered below,
  // so nothing on the bus side reaches an output combinationally.
  always_comb begin
    state_nx   = state;
    lat_cnt_nx = lat_cnt;
    ack_nx     = 1'b0;
    err_nx     = 1'b0;
    csb_nx     = 1'b1;
    web_nx     = 1'b1;
    wmask_nx   = mem_wmask_o;
    addr_nx    = mem_addr_o;
    din_nx     = mem_din_o;
    dat_nx     = wb_dat_o;
    case (state)
      IDLE: begin
        if (wb_cyc_i && wb_stb_i) begin
          if (out_of_range) begin
            state_nx = ERR;
            err_nx   = 1'b1;
          end else begin
            addr_nx = MEM_AW'(idx);
            csb_nx  = 1'b0;
            if (wb_we_i) begin
              web_nx   = 1'b0;
              wmask_nx = wb_sel_i;
              din_nx   = wb_dat_i;
              state_nx = WRITE;
            end else begin
              wmask_nx = 4'h0;
              state_nx = READ;
            end
          end
        end
      end
      WRITE: begin
        wmask_nx = 4'h0;
        if (!wb_cyc_i) state_nx = IDLE;
        else begin
          state_nx = ACK;
          ack_nx   = 1'b1;
        end
      end
      READ: begin
        lat_cnt_nx = 2'(READ_LATENCY - 1);
        state_nx   = wb_cyc_i ? WAIT : IDLE;
      end
      WAIT: begin
        if (!wb_cyc_i) state_nx = IDLE;
        else if (lat_cnt == 2'd0) begin
          dat_nx   = mem_dout_i;
          ack_nx   = 1'b1;
          state_nx = ACK;
        end else lat_cnt_nx = lat_cnt - 2'd1;
      end
      ACK:     state_nx = IDLE;
      ERR:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      lat_cnt     <= 2'd0;
      wb_ack_o    <= 1'b0;
      wb_err_o    <= 1'b0;
      wb_dat_o    <= 32'h0;
      mem_csb_o   <= 1'b1;
      mem_web_o   <= 1'b1;
      mem_wmask_o <= 4'h0;
      mem_addr_o  <= '0;
      mem_din_o   <= 32'h0;
    end else begin
      state       <= state_nx;
      lat_cnt     <= lat_cnt_nx;
      wb_ack_o    <= ack_nx;
      wb_err_o    <= err_nx;
      wb_dat_o    <= dat_nx;
      mem_csb_o   <= csb_nx;
      mem_web_o   <= web_nx;
      mem_wmask_o <= wmask_nx;
      mem_addr_o  <= addr_nx;
      mem_din_o   <= din_nx;
    end
  end
endmodule

// File: tb/tb_wb_sram_responder.sv
// Directed bench: three responders (latency 1, latency 3, depth 192) share one
// Wishbone initiator; each has its own behavioural SRAM macro.
module tb_wb_sram_responder;
  logic        clock, reset;
  logic        cyc, stb, we;
  logic [3:0]  sel;
  logic [9:0]  addr;
  logic [31:0] wdat;

  logic        d1_ack, d1_err, d1_csb, d1_web;
  logic [3:0]  d1_wmask;
  logic [7:0]  d1_addr;
  logic [31:0] d1_din, d1_dat, d1_dout;
  logic        d3_ack, d3_err, d3_csb, d3_web;
  logic [3:0]  d3_wmask;
  logic [7:0]  d3_addr;
  logic [31:0] d3_din, d3_dat, d3_dout;
  logic        dd_ack, dd_err, dd_csb, dd_web;
  logic [3:0]  dd_wmask;
  logic [7:0]  dd_addr;
  logic [31:0] dd_din, dd_dat, dd_dout;

  int n_chk = 0, n_fail = 0;
  int str1 = 0, strdd = 0;

  logic [79:0] d1_vec, d3_vec;
  logic [79:0] rst_vec;
  assign d1_vec  = {d1_ack, d1_err, d1_csb, d1_web, d1_wmask, d1_addr, d1_din, d1_dat};
  assign d3_vec  = {d3_ack, d3_err, d3_csb, d3_web, d3_wmask, d3_addr, d3_din, d3_dat};
  assign rst_vec = {1'b0, 1'b0, 1'b1, 1'b1, 4'h0, 8'h00, 32'h0, 32'h0};

  wb_sram_responder #(.READ_LATENCY(1)) dut (
    .clock(clock), .reset(reset), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we),
    .wb_sel_i(sel), .wb_addr_i(addr), .wb_dat_i(wdat), .wb_ack_o(d1_ack),
    .wb_err_o(d1_err), .wb_dat_o(d1_dat), .mem_csb_o(d1_csb), .mem_web_o(d1_web),
    .mem_wmask_o(d1_wmask), .mem_addr_o(d1_addr), .mem_din_o(d1_din), .mem_dout_i(d1_dout));

  wb_sram_responder #(.READ_LATENCY(3)) dut3 (
    .clock(clock), .reset(reset), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we),
    .wb_sel_i(sel), .wb_addr_i(addr), .wb_dat_i(wdat), .wb_ack_o(d3_ack),
    .wb_err_o(d3_err), .wb_dat_o(d3_dat), .mem_csb_o(d3_csb), .mem_web_o(d3_web),
    .mem_wmask_o(d3_wmask), .mem_addr_o(d3_addr), .mem_din_o(d3_din), .mem_dout_i(d3_dout));

  wb_sram_responder #(.DEPTH(192)) dutd (
    .clock(clock), .reset(reset), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we),
    .wb_sel_i(sel), .wb_addr_i(addr), .wb_dat_i(wdat), .wb_ack_o(dd_ack),
    .wb_err_o(dd_err), .wb_dat_o(dd_dat), .mem_csb_o(dd_csb), .mem_web_o(dd_web),
    .mem_wmask_o(dd_wmask), .mem_addr_o(dd_addr), .mem_din_o(dd_din), .mem_dout_i(dd_dout));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Macro models: word 0 preloaded so an aborted read of it would be visible.
  initial begin
    logic [31:0] m [256];
    for (int i = 0; i < 256; i++) m[i] = 32'h0;
    m[0] = 32'h1234_5678;
    d1_dout = 32'h0;
    forever begin
      @(posedge clock);
      if (!d1_csb) begin
        if (!d1_web) begin
          for (int b = 0; b < 4; b++) if (d1_wmask[b]) m[d1_addr][b*8 +: 8] = d1_din[b*8 +: 8];
        end else d1_dout <= m[d1_addr];
      end
    end
  end

  initial begin
    logic [31:0] m [256];
    logic [31:0] p0, p1;
    for (int i = 0; i < 256; i++) m[i] = 32'h0;
    m[0] = 32'h1234_5678;
    p0 = 32'h0; p1 = 32'h0; d3_dout = 32'h0;
    forever begin
      @(posedge clock);
      d3_dout <= p1;
      p1 <= p0;
      if (!d3_csb) begin
        if (!d3_web) begin
          for (int b = 0; b < 4; b++) if (d3_wmask[b]) m[d3_addr][b*8 +: 8] = d3_din[b*8 +: 8];
        end else p0 <= m[d3_addr];
      end
    end
  end

  initial begin
    logic [31:0] m [256];
    for (int i = 0; i < 256; i++) m[i] = 32'h0;
    m[0] = 32'h1234_5678;
    dd_dout = 32'h0;
    forever begin
      @(posedge clock);
      if (!dd_csb) begin
        if (!dd_web) begin
          for (int b = 0; b < 4; b++) if (dd_wmask[b]) m[dd_addr][b*8 +: 8] = dd_din[b*8 +: 8];
        end else dd_dout <= m[dd_addr];
      end
    end
  end

  always @(negedge clock) begin
    if (!d1_csb) str1 <= str1 + 1;
    if (!dd_csb) strdd <= strdd + 1;
  end

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  // Latency = number of edges from the accepting edge to the one that samples ack high.
  task automatic wait_d1(output int lat);
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clock);
      if (d1_ack) begin
        lat = k;
        break;
      end
    end
    if (lat == 0) lat = 99;
  endtask

  task automatic test_reset;
    int acks;
    reset = 1'b1; cyc = 0; stb = 0; we = 0; sel = 0; addr = 0; wdat = 0;
    repeat (2) tick();
    n_chk++; if (d1_vec !== rst_vec) begin n_fail++; $display("FAIL reset_init: got %h want %h", d1_vec, rst_vec); end
    reset = 1'b0;
    tick();
    cyc = 1; stb = 1; we = 0; addr = 10'h084;
    tick();
    stb = 0;
    tick();
    reset = 1'b1;
    #1;
    n_chk++; if (d1_vec !== rst_vec) begin n_fail++; $display("FAIL reset_mid_d1: got %h want %h", d1_vec, rst_vec); end
    n_chk++; if (d3_vec !== rst_vec) begin n_fail++; $display("FAIL reset_mid_d3: got %h want %h", d3_vec, rst_vec); end
    cyc = 0;
    tick();
    reset = 1'b0;
    acks = 0;
    repeat (10) begin
      tick();
      if (d1_ack || d3_ack || dd_ack || d1_err || d3_err || dd_err) acks++;
    end
    n_chk++; if (acks != 0) begin n_fail++; $display("FAIL reset_no_ack: got %0d acks want 0", acks); end
  endtask

  task automatic test_write;
    int lat, s;
    s = str1;
    cyc = 1; stb = 1; we = 1; sel = 4'b0100; addr = 10'h084; wdat = 32'hDDDD_DDDD;
    tick();
    stb = 0;
    n_chk++; if ({d1_csb, d1_web} !== 2'b00) begin n_fail++; $display("FAIL write_strobe: got %b want 00", {d1_csb, d1_web}); end
    n_chk++; if (d1_addr !== 8'h21) begin n_fail++; $display("FAIL write_addr: got %h want 21", d1_addr); end
    n_chk++; if (d1_wmask !== 4'b0100) begin n_fail++; $display("FAIL write_wmask: got %b want 0100", d1_wmask); end
    n_chk++; if (d1_din !== 32'hDDDD_DDDD) begin n_fail++; $display("FAIL write_din: got %h want dddddddd", d1_din); end
    wait_d1(lat);
    n_chk++; if (lat != 2) begin n_fail++; $display("FAIL write_latency: got %0d want 2", lat); end
    n_chk++; if (d1_csb !== 1'b1) begin n_fail++; $display("FAIL write_csb_release: got %b want 1", d1_csb); end
    cyc = 0;
    tick(); tick();
    n_chk++; if (str1 - s != 1) begin n_fail++; $display("FAIL write_strobe_count: got %0d want 1", str1 - s); end
  endtask

  task automatic test_read;
    int l1, l3;
    logic [31:0] v1, v3;
    l1 = 0; l3 = 0; v1 = 0; v3 = 0;
    cyc = 1; stb = 1; we = 0; sel = 4'b0001; addr = 10'h084;
    tick();
    stb = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clock);
      if (d1_ack && l1 == 0) begin l1 = k; v1 = d1_dat; end
      if (d3_ack && l3 == 0) begin l3 = k; v3 = d3_dat; end
    end
    cyc = 0;
    n_chk++; if (l1 != 3) begin n_fail++; $display("FAIL read_lat1: got %0d want 3", l1); end
    n_chk++; if (v1 !== 32'h00DD_0000) begin n_fail++; $display("FAIL read_data1: got %h want 00dd0000", v1); end
    n_chk++; if (l3 != 5) begin n_fail++; $display("FAIL read_lat3: got %0d want 5", l3); end
    n_chk++; if (v3 !== 32'h00DD_0000) begin n_fail++; $display("FAIL read_data3: got %h want 00dd0000", v3); end
    tick();
    n_chk++; if (d1_dat !== 32'h00DD_0000) begin n_fail++; $display("FAIL read_data_hold: got %h want 00dd0000", d1_dat); end
  endtask

  task automatic test_error;
    int s;
    s = strdd;
    cyc = 1; stb = 1; we = 0; addr = 10'h300;
    tick();
    stb = 0; cyc = 0;
    n_chk++; if ({dd_err, dd_ack} !== 2'b10) begin n_fail++; $display("FAIL err_raise: got %b want 10", {dd_err, dd_ack}); end
    tick();
    n_chk++; if (dd_err !== 1'b0) begin n_fail++; $display("FAIL err_one_cycle: got %b want 0", dd_err); end
    n_chk++; if (dd_dat !== 32'h00DD_0000) begin n_fail++; $display("FAIL err_dat_kept: got %h want 00dd0000", dd_dat); end
    repeat (4) tick();
    n_chk++; if (strdd - s != 0) begin n_fail++; $display("FAIL err_no_strobe: got %0d want 0", strdd - s); end
    n_chk++; if (d1_dat !== 32'h00DD_0000) begin n_fail++; $display("FAIL abort_read_dat: got %h want 00dd0000", d1_dat); end
  endtask

  task automatic test_abort;
    int acks, lat;
    cyc = 1; stb = 1; we = 0; addr = 10'h000;
    tick();
    stb = 0;
    tick();
    cyc = 0;
    acks = 0;
    repeat (6) begin
      tick();
      if (d1_ack || d3_ack) acks++;
    end
    n_chk++; if (acks != 0) begin n_fail++; $display("FAIL abort_no_ack: got %0d want 0", acks); end
    n_chk++; if (d1_dat !== 32'h00DD_0000) begin n_fail++; $display("FAIL abort_dat_kept: got %h want 00dd0000", d1_dat); end
    cyc = 1; stb = 1; we = 1; sel = 4'hF; addr = 10'h000; wdat = 32'hA5A5_A5A5;
    tick();
    stb = 0;
    wait_d1(lat);
    n_chk++; if (lat != 2) begin n_fail++; $display("FAIL abort_then_write: got %0d want 2", lat); end
    cyc = 0;
    tick(); tick();
  endtask

  task automatic test_back_to_back;
    int t [3];
    int na, s;
    na = 0; s = str1;
    t[0] = 0; t[1] = 0; t[2] = 0;
    cyc = 1; stb = 1; we = 0; addr = 10'h084;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clock);
      if (d1_ack) begin
        t[na] = n;
        na++;
        if (na == 3) break;
      end
    end
    cyc = 0; stb = 0;
    n_chk++; if (na != 3) begin n_fail++; $display("FAIL b2b_ack_count: got %0d want 3", na); end
    n_chk++; if (t[1] - t[0] != 4) begin n_fail++; $display("FAIL b2b_gap1: got %0d want 4", t[1] - t[0]); end
    n_chk++; if (t[2] - t[1] != 4) begin n_fail++; $display("FAIL b2b_gap2: got %0d want 4", t[2] - t[1]); end
    n_chk++; if (d1_dat !== 32'h00DD_0000) begin n_fail++; $display("FAIL b2b_data: got %h want 00dd0000", d1_dat); end
    tick(); tick(); tick();
    n_chk++; if (str1 - s != 3) begin n_fail++; $display("FAIL b2b_strobes: got %0d want 3", str1 - s); end
    n_chk++; if (d1_ack !== 1'b0) begin n_fail++; $display("FAIL b2b_idle_ack: got %b want 0", d1_ack); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_error();
    test_abort();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/wb_sram_responder.md
Name: wb_sram_responder

Overview:
Wishbone classic target that fronts a single-port OpenRAM-style SRAM macro and answers pmem's SRAM initiator port (cyc/stb/we/sel/addr/dat, ack).
- Registers each request, drives one macro access, waits the macro read latency, returns a one-cycle ack and the read word.
- Signals an error for word addresses beyond the macro depth.
- Sits between pmem and the SRAM macro in the user-project wrapper.

Parameters:
ADDR_WIDTH, 10, width of Wishbone byte address.
DEPTH, 256, macro depth in 32-bit words. Word index >= DEPTH is out of range.
MEM_AW, 8, macro address width.
READ_LATENCY, 1, cycles from macro read strobe to valid mem_dout_i. Legal range 1..3.

Ports:
clock  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-high reset
wb_cyc_i  in  1  bus cycle valid
wb_stb_i  in  1  strobe
wb_we_i  in  1  1=write, 0=read
wb_sel_i  in  4  byte lane select
wb_addr_i  in  ADDR_WIDTH  byte address; bits [1:0] ignored
wb_dat_i  in  32  write data
wb_ack_o  out  1  one-cycle completion
wb_err_o  out  1  one-cycle error completion (out-of-range)
wb_dat_o  out  32  read data, valid while wb_ack_o=1, held until next read completes
mem_csb_o  out  1  macro chip select, active low
mem_web_o  out  1  macro write enable, active low
mem_wmask_o  out  4  macro byte write mask
mem_addr_o  out  MEM_AW  macro word address
mem_din_o  out  32  macro write data
mem_dout_i  in  32  macro read data

Behaviour:
- Reset values (asynchronous): wb_ack_o=0, wb_err_o=0, wb_dat_o=0, mem_csb_o=1, mem_web_o=1, mem_wmask_o=0, mem_addr_o=0, mem_din_o=0. State is IDLE and the latency counter is 0.
- All outputs are registered. There is no combinational path from wb_* inputs to any output.
- Word index is wb_addr_i[ADDR_WIDTH-1:2]. mem_addr_o gets its low MEM_AW bits.
- States: IDLE, WRITE, READ, WAIT, ACK, ERR.
- IDLE: a request is accepted when wb_cyc_i & wb_stb_i are high at a rising edge.
  - Index >= DEPTH: go to ERR. The macro is untouched (mem_csb_o stays 1).
  - wb_we_i=1: latch addr, wb_dat_i→mem_din_o, wb_sel_i→mem_wmask_o; go to WRITE.
  - wb_we_i=0: latch addr; go to READ.
- WRITE (1 cycle): mem_csb_o=0, mem_web_o=0. Next state ACK.
- READ (1 cycle): mem_csb_o=0, mem_web_o=1, mem_wmask_o=0. Load counter=READ_LATENCY-1. Next state WAIT.
- WAIT: mem_csb_o=1. While the counter is nonzero, decrement it. When the counter is 0, capture mem_dout_i into wb_dat_o and go to ACK.
- ACK: wb_ack_o=1 for exactly one cycle, then IDLE.
- ERR: wb_err_o=1 for exactly one cycle, then IDLE. wb_dat_o is unchanged.
- Latency, counted from the accepting edge to the edge where ack is sampled high:
  - write = 2 cycles
  - read = 2 + READ_LATENCY cycles
  - err = 1 cycle
- Acks are never issued in IDLE. A request still held after ack is treated as a new request at the first IDLE edge. Minimum spacing between consecutive acks: write 3 cycles, read 3+READ_LATENCY cycles.
- wb_ack_o and wb_err_o are never high together.
- Write with wb_sel_i=0: the macro strobe is still issued with wmask=0, the memory is unchanged, and ack is returned.
- Read returns the full 32-bit word regardless of wb_sel_i. Byte extraction is the initiator's job.
- Abort: wb_cyc_i=0 sampled in WRITE, READ or WAIT sends the FSM to IDLE next cycle and suppresses ack/err. A macro strobe already driven is not retracted. wb_dat_o keeps its old value.
- wb_stb_i dropping while wb_cyc_i is high mid-transaction is ignored; the transaction completes.
- Reset asserted mid-transaction: outputs take reset values immediately. No ack is produced.

Test Plan:
1. Assert reset while a read is in WAIT. Check all outputs are at reset values immediately and mem_csb_o=1. Release reset; check there is no ack for 10 cycles.
2. Write: addr 0x084, sel 4'b0100, dat 0xDDDDDDDD. Check mem_addr_o=0x21, mem_wmask_o=4'b0100, mem_web_o=0 and mem_csb_o=0 for one cycle, and ack exactly 2 cycles after the accepting edge.
3. Read addr 0x084 with the macro model returning 0x00DD0000.
   - READ_LATENCY=1: ack at cycle 3 with wb_dat_o=0x00DD0000.
   - READ_LATENCY=3: ack at cycle 5 with the same data.
4. DEPTH=192: read addr 0x300 (word 192). Check wb_err_o=1 one cycle after acceptance, mem_csb_o never low, and wb_dat_o unchanged.
5. Start a read, then drop wb_cyc_i in WAIT. Check no ack, FSM returns to IDLE, and a following write to 0x000 acks at 2 cycles.
6. Hold cyc/stb/we=0 across 3 reads with READ_LATENCY=1. Check acks are spaced exactly 4 cycles apart and there are exactly 3 macro strobes.
